// File: rtl/melody_sched.sv
// Score-driven melody player sharing one tone generator with live note keys.
// A 64-entry score RAM is stepped through beat by beat; pressed keys pre-empt playback.
module melody_sched #(
  parameter int unsigned CLK_HZ   = 25000000,
  parameter int unsigned BEAT_CYC = 10000000,
  parameter int unsigned GAP_CYC  = 250000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [5:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        play,
  input  logic        stop,
  input  logic [7:0]  key,
  output logic        tone_en,
  output logic [15:0] half_period,
  output logic        busy,
  output logic [5:0]  note_idx,
  output logic        done
);

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;
  localparam int unsigned HW = 16;
  localparam int unsigned CW = 32;

  localparam logic [HW-1:0] HP_DO  = HW'(CLK_HZ / 262 / 2);
  localparam logic [HW-1:0] HP_RE  = HW'(CLK_HZ / 294 / 2);
  localparam logic [HW-1:0] HP_MI  = HW'(CLK_HZ / 330 / 2);
  localparam logic [HW-1:0] HP_FA  = HW'(CLK_HZ / 349 / 2);
  localparam logic [HW-1:0] HP_SOL = HW'(CLK_HZ / 392 / 2);
  localparam logic [HW-1:0] HP_LA  = HW'(CLK_HZ / 440 / 2);
  localparam logic [HW-1:0] HP_SI  = HW'(CLK_HZ / 494 / 2);
  localparam logic [HW-1:0] HP_DO2 = HW'(CLK_HZ / 523 / 2);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, KEY} state_t;

  state_t          state, state_nx, ret_state, ret_nx;
  logic [CW-1:0]   cnt, cnt_nx, play_len, play_len_nx;
  logic [3:0]      code, code_nx;
  logic [AW-1:0]   idx_nx;
  logic            tone_nx, busy_nx, done_nx;
  logic [HW-1:0]   hp_nx;
  logic [DW-1:0]   score [64];
  logic [DW-1:0]   entry;
  logic [3:0]      dur;

  function automatic logic [HW-1:0] hp_of(input logic [3:0] c);
    case (c)
      4'd1:    hp_of = HP_DO;
      4'd2:    hp_of = HP_RE;
      4'd3:    hp_of = HP_MI;
      4'd4:    hp_of = HP_FA;
      4'd5:    hp_of = HP_SOL;
      4'd6:    hp_of = HP_LA;
      4'd7:    hp_of = HP_SI;
      4'd8:    hp_of = HP_DO2;
      default: hp_of = '0;
    endcase
  endfunction

  function automatic logic is_note(input logic [3:0] c);
    is_note = (c >= 4'd1) && (c <= 4'd8);
  endfunction

  // Lowest pressed key wins; returns the matching note code.
  function automatic logic [3:0] key_code(input logic [7:0] k);
    key_code = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (k[i]) key_code = 4'(i + 1);
    end
  endfunction

  // Score RAM: write-only port is synchronous and never reset.
  always_ff @(posedge clk) begin
    if (wr_en) score[wr_addr] <= wr_data;
  end

  assign entry = score[note_idx];
  assign dur   = entry[7:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ret_state   <= IDLE;
      cnt         <= '0;
      play_len    <= '0;
      code        <= '0;
      note_idx    <= '0;
      tone_en     <= 1'b0;
      half_period <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      ret_state   <= ret_nx;
      cnt         <= cnt_nx;
      play_len    <= play_len_nx;
      code        <= code_nx;
      note_idx    <= idx_nx;
      tone_en     <= tone_nx;
      half_period <= hp_nx;
      busy        <= busy_nx;
      done        <= done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    ret_nx      = ret_state;
    cnt_nx      = cnt;
    play_len_nx = play_len;
    code_nx     = code;
    idx_nx      = note_idx;
    done_nx     = 1'b0;

    if (stop) begin
      state_nx = IDLE;
      idx_nx   = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (key != 8'd0) begin
            state_nx = KEY;
            ret_nx   = IDLE;
          end else if (play) begin
            state_nx = LOAD;
            idx_nx   = '0;
          end
        end
        LOAD: begin
          if (dur == 4'd0) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx    = PLAY;
            cnt_nx      = '0;
            play_len_nx = CW'(dur) * CW'(BEAT_CYC) - CW'(GAP_CYC);
            code_nx     = entry[3:0];
          end
        end
        PLAY: begin
          if (key != 8'd0) begin
            state_nx = KEY;
            ret_nx   = PLAY;
          end else if (cnt == play_len - CW'(1)) begin
            cnt_nx = '0;
            if (GAP_CYC != 0) begin
              state_nx = GAP;
            end else begin
              state_nx = LOAD;
              idx_nx   = note_idx + AW'(1);
            end
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        GAP: begin
          if (key != 8'd0) begin
            state_nx = KEY;
            ret_nx   = GAP;
          end else if (cnt == CW'(GAP_CYC) - CW'(1)) begin
            cnt_nx   = '0;
            state_nx = LOAD;
            idx_nx   = note_idx + AW'(1);
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        KEY: begin
          if (key == 8'd0) state_nx = ret_state;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs track the state being entered so they line up with it cycle for cycle.
  always_comb begin
    tone_nx = 1'b0;
    hp_nx   = half_period;
    busy_nx = (state_nx != IDLE);
    case (state_nx)
      PLAY: begin
        if (is_note(code_nx)) begin
          tone_nx = 1'b1;
          hp_nx   = hp_of(code_nx);
        end
      end
      KEY: begin
        tone_nx = 1'b1;
        hp_nx   = hp_of(key_code(key));
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_melody_sched.sv
// Bench for melody_sched: directed scenarios plus random traffic checked
// against a countdown-based reference model of the player.
module tb_melody_sched;

  localparam int BEAT = 10;
  localparam int GAPC = 2;
  localparam int S_IDLE = 0, S_LOAD = 1, S_TONE = 2, S_GAP = 3;

  logic        clk = 1'b0;
  logic        rst_n, wr_en, play, stop;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data, key;
  logic        tone_en, busy, done;
  logic [15:0] half_period;
  logic [5:0]  note_idx;

  melody_sched #(.CLK_HZ(25000000), .BEAT_CYC(BEAT), .GAP_CYC(GAPC)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .play(play), .stop(stop), .key(key), .tone_en(tone_en), .half_period(half_period),
    .busy(busy), .note_idx(note_idx), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  ram [64];
  int          m_seg, m_left, m_idx;
  bit          m_key, m_done;
  logic [3:0]  m_code;
  logic [15:0] m_hp;

  function automatic int hp_tbl(input int n);
    case (n)
      1: return 47709;
      2: return 42517;
      3: return 37878;
      4: return 35816;
      5: return 31887;
      6: return 28409;
      7: return 25303;
      8: return 23900;
      default: return 0;
    endcase
  endfunction

  function automatic int lowest(input logic [7:0] k);
    for (int i = 0; i < 8; i++) if (k[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_seg = S_IDLE; m_left = 0; m_idx = 0; m_key = 1'b0; m_done = 1'b0;
    m_code = 4'd0; m_hp = 16'd0;
  endtask

  // One clock of the reference player: segments count down remaining cycles,
  // and a held key overlays the melody without consuming any of its time.
  task automatic model_edge();
    logic [7:0] e;
    m_done = 1'b0;
    if (stop) begin
      m_seg = S_IDLE; m_key = 1'b0; m_idx = 0;
    end else if (m_key) begin
      if (key == 8'h00) m_key = 1'b0;
    end else begin
      case (m_seg)
        S_IDLE: if (key != 8'h00) m_key = 1'b1;
                else if (play) begin m_seg = S_LOAD; m_idx = 0; end
        S_LOAD: begin
          e = ram[m_idx];
          if (e[7:4] == 4'd0) begin m_seg = S_IDLE; m_done = 1'b1; end
          else begin m_seg = S_TONE; m_left = int'(e[7:4]) * BEAT - GAPC; m_code = e[3:0]; end
        end
        S_TONE: if (key != 8'h00) m_key = 1'b1;
                else begin m_left--; if (m_left == 0) begin m_seg = S_GAP; m_left = GAPC; end end
        S_GAP:  if (key != 8'h00) m_key = 1'b1;
                else begin m_left--; if (m_left == 0) begin m_seg = S_LOAD; m_idx = (m_idx + 1) % 64; end end
        default: ;
      endcase
    end
    if (wr_en) ram[wr_addr] = wr_data;
    if (m_key) m_hp = 16'(hp_tbl(lowest(key) + 1));
    else if (m_seg == S_TONE && m_code >= 1 && m_code <= 8) m_hp = 16'(hp_tbl(int'(m_code)));
  endtask

  task automatic check_all();
    chk("tone_en", 32'(tone_en), 32'(m_key || (m_seg == S_TONE && m_code >= 1 && m_code <= 8)));
    chk("half_period", 32'(half_period), 32'(m_hp));
    chk("busy", 32'(busy), 32'(m_key || m_seg != S_IDLE));
    chk("note_idx", 32'(note_idx), 32'(m_idx));
    chk("done", 32'(done), 32'(m_done));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    int tone_hi, done_at, done_cnt, idx1_at, busy_cnt, prev_idx;
    bit found, wrapped;
    for (int i = 0; i < 64; i++) ram[i] = 8'h00;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    play = 1'b0; stop = 1'b0; key = 8'h00;
    model_reset();
    #12;
    chk("rst_tone", 32'(tone_en), 0);
    chk("rst_hp", 32'(half_period), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idx", 32'(note_idx), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) wr(i, 8'h00);

    // Two-note melody with end marker.
    wr(0, 8'h21); wr(1, 8'h13); wr(2, 8'h00);
    play = 1'b1; step(); play = 1'b0;
    tone_hi = 0; done_at = -1; done_cnt = 0; idx1_at = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (tone_en) tone_hi++;
      if (done) begin done_cnt++; if (done_at < 0) done_at = k; end
      if (note_idx == 6'd1 && idx1_at < 0) idx1_at = k;
    end
    chk("mel_tone_cycles", 32'(tone_hi), 26);
    chk("mel_load_interval", 32'(idx1_at), 21);
    chk("mel_done_at", 32'(done_at), 33);
    chk("mel_done_count", 32'(done_cnt), 1);

    // Rest note keeps the tone off while busy.
    wr(0, 8'h20); wr(1, 8'h00);
    play = 1'b1; step(); play = 1'b0;
    tone_hi = 0; busy_cnt = 1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (tone_en) tone_hi++;
      if (busy) busy_cnt++;
    end
    chk("rest_tone_cycles", 32'(tone_hi), 0);
    chk("rest_busy_cycles", 32'(busy_cnt), 22);

    // Key press during PLAY freezes the note and resumes it afterwards.
    wr(0, 8'h31);
    play = 1'b1; step(); play = 1'b0;
    done_at = -1;
    for (int k = 1; k <= 60; k++) begin
      if (k == 6) key = 8'h24;
      if (k == 11) key = 8'h00;
      step();
      if (k == 8) begin
        chk("key_hp", 32'(half_period), 32'(hp_tbl(lowest(8'h24) + 1)));
        chk("key_tone", 32'(tone_en), 1);
      end
      if (done && done_at < 0) done_at = k;
    end
    chk("key_done_at", 32'(done_at), 32 + 5 + 1);

    // Stop while the second note plays.
    wr(0, 8'h11); wr(1, 8'h11); wr(2, 8'h00);
    play = 1'b1; step(); play = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (note_idx == 6'd1) found = 1'b1;
    end
    chk("reach_idx1", 32'(found), 1);
    step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_idx", 32'(note_idx), 0);
    chk("stop_tone", 32'(tone_en), 0);
    chk("stop_done", 32'(done), 0);

    // Full score wraps from 63 to 0 without ending.
    for (int i = 0; i < 64; i++) wr(i, 8'h11);
    play = 1'b1; step(); play = 1'b0;
    wrapped = 1'b0; done_cnt = 0; prev_idx = 0;
    for (int k = 0; k < 64 * 11 + 20; k++) begin
      step();
      if (prev_idx == 63 && note_idx == 6'd0) wrapped = 1'b1;
      if (done) done_cnt++;
      prev_idx = int'(note_idx);
    end
    chk("wrap_seen", 32'(wrapped), 1);
    chk("wrap_no_done", 32'(done_cnt), 0);
    chk("wrap_busy", 32'(busy), 1);
    stop = 1'b1; step(); stop = 1'b0;

    // Random score, writes, keys, play and stop traffic.
    for (int i = 0; i < 64; i++)
      wr(i, {4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))});
    for (int k = 0; k < 1500; k++) begin
      play = ($urandom_range(0, 14) == 0);
      stop = ($urandom_range(0, 399) == 0);
      if (key == 8'h00) begin
        if ($urandom_range(0, 39) == 0) key = 8'($urandom_range(1, 255));
      end else if ($urandom_range(0, 3) == 0) key = 8'h00;
      wr_en = ($urandom_range(0, 9) == 0);
      wr_addr = 6'($urandom_range(0, 63));
      wr_data = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
      step();
    end
    play = 1'b0; key = 8'h00; wr_en = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;

    // Asynchronous reset in GAP keeps the score for a replay.
    wr(0, 8'h21); wr(1, 8'h13); wr(2, 8'h00);
    play = 1'b1; step(); play = 1'b0;
    for (int k = 1; k <= 19; k++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tone", 32'(tone_en), 0);
    chk("arst_hp", 32'(half_period), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_idx", 32'(note_idx), 0);
    chk("arst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    play = 1'b1; step(); play = 1'b0;
    tone_hi = 0; done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (tone_en) tone_hi++;
      if (done && done_at < 0) done_at = k;
    end
    chk("replay_tone_cycles", 32'(tone_hi), 26);
    chk("replay_done_at", 32'(done_at), 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
